// File: rtl/pipelined_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_control_unit
//  Description : ID-stage decoder and ID/EX control register for a five-stage
//                LEGv8-style pipeline. Produces the combinational branch and
//                hazard decisions in ID, the registered EX control bundle,
//                and the architectural NZCV register.
//                Optional feature macro: CTRL_FLAG_FWD_EN. When it is defined,
//                a B.cond in ID uses the NZCV result of the flag-setting
//                instruction in EX directly. When it is undefined, the B.cond
//                stalls for one cycle and then reads flags_q.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipelined_control_unit #(
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        instr,
    input  logic               id_valid,
    input  logic               stall_in,
    input  logic               flush,
    input  logic [3:0]         alu_nzcv,
    input  logic               cbz_zero,
    output logic               reg2loc,
    output logic               reg3loc,
    output logic               uncond_br,
    output logic               br_taken,
    output logic               is_br,
    output logic               hazard_stall,
    output logic               ex_valid,
    output logic               ex_reg_write,
    output logic               ex_alu_src,
    output logic               ex_is_addi,
    output logic               ex_mem_write,
    output logic               ex_read_en,
    output logic               ex_flag_en,
    output logic [1:0]         ex_mem_to_reg,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic [REG_AW-1:0]  ex_rd,
    output logic [3:0]         flags_q
);

    // Parameter sanity: refuse to elaborate an unsupported configuration
    if (ALUOP_W < 3 || ALUOP_W > 8) begin : g_bad_aluop_w
        $error("pipelined_control_unit: ALUOP_W must be within 3..8");
    end
    if (REG_AW < 5) begin : g_bad_reg_aw
        $error("pipelined_control_unit: REG_AW must be at least 5");
    end

    // Opcode fields
    localparam logic [10:0] c_OP_ADDS  = 11'b10101011000;
    localparam logic [10:0] c_OP_SUBS  = 11'b11101011000;
    localparam logic [10:0] c_OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] c_OP_STUR  = 11'b11111000000;
    localparam logic [10:0] c_OP_BR    = 11'b11010110000;
    localparam logic [9:0]  c_OP_ADDI  = 10'b1001000100;
    localparam logic [7:0]  c_OP_CBZ   = 8'b10110100;
    localparam logic [7:0]  c_OP_BCOND = 8'b01010100;
    localparam logic [5:0]  c_OP_B     = 6'b000101;
    localparam logic [5:0]  c_OP_BL    = 6'b100101;

    // ALU operation codes and write-back selects
    localparam logic [ALUOP_W-1:0] c_ALU_PASSB = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] c_ALU_ADD   = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] c_ALU_SUB   = ALUOP_W'(3);
    localparam logic [1:0]         c_WB_ALU    = 2'b00;
    localparam logic [1:0]         c_WB_MEM    = 2'b01;
    localparam logic [1:0]         c_WB_PC4    = 2'b10;
    localparam logic [REG_AW-1:0]  c_REG_LR    = REG_AW'(30);
    localparam logic [REG_AW-1:0]  c_REG_ZR    = REG_AW'(31);

    typedef struct packed {
        logic               valid;
        logic               reg_write;
        logic               alu_src;
        logic               is_addi;
        logic               mem_write;
        logic               read_en;
        logic               flag_en;
        logic [1:0]         mem_to_reg;
        logic [ALUOP_W-1:0] aluop;
        logic [REG_AW-1:0]  rd;
    } ex_bundle_t;

    ex_bundle_t r_ex;
    ex_bundle_t w_dec;
    logic [3:0] r_flags;

    logic w_is_addi, w_is_adds, w_is_subs, w_is_ldur, w_is_stur;
    logic w_is_b, w_is_bl, w_is_br, w_is_cbz, w_is_bcond, w_known;
    logic w_uses_rn, w_uses_rm, w_uses_rt;
    logic w_load_use, w_flag_hz, w_ex_flags_live, w_id_live, w_go, w_kill;
    logic w_cond_base, w_cond_ok;
    logic [3:0] w_flags_src;
    logic [3:0] w_cond;
    logic w_unused;

    // Shift-amount field is never consulted by the control path
    assign w_unused = ^instr[15:10];

    assign w_is_addi  = (instr[31:22] == c_OP_ADDI);
    assign w_is_adds  = (instr[31:21] == c_OP_ADDS);
    assign w_is_subs  = (instr[31:21] == c_OP_SUBS);
    assign w_is_ldur  = (instr[31:21] == c_OP_LDUR);
    assign w_is_stur  = (instr[31:21] == c_OP_STUR);
    assign w_is_br    = (instr[31:21] == c_OP_BR);
    assign w_is_cbz   = (instr[31:24] == c_OP_CBZ);
    assign w_is_bcond = (instr[31:24] == c_OP_BCOND);
    assign w_is_b     = (instr[31:26] == c_OP_B);
    assign w_is_bl    = (instr[31:26] == c_OP_BL);
    assign w_known    = w_is_addi | w_is_adds | w_is_subs | w_is_ldur | w_is_stur |
                        w_is_b | w_is_bl | w_is_br | w_is_cbz | w_is_bcond;

    // Which register fields the ID instruction actually reads
    assign w_uses_rn = w_is_addi | w_is_adds | w_is_subs | w_is_ldur | w_is_stur;
    assign w_uses_rm = w_is_adds | w_is_subs;
    assign w_uses_rt = w_is_stur | w_is_cbz | w_is_br;

    // Load-use: the EX load's destination is consumed here; XZR never conflicts
    assign w_load_use = r_ex.valid & r_ex.read_en & (r_ex.rd != c_REG_ZR) &
                        ((w_uses_rn & (r_ex.rd == REG_AW'(instr[9:5])))  |
                         (w_uses_rm & (r_ex.rd == REG_AW'(instr[20:16]))) |
                         (w_uses_rt & (r_ex.rd == REG_AW'(instr[4:0]))));

    assign w_ex_flags_live = r_ex.valid & r_ex.flag_en;

`ifdef CTRL_FLAG_FWD_EN
    assign w_flags_src = w_ex_flags_live ? alu_nzcv : r_flags;
    assign w_flag_hz   = 1'b0;
`else
    assign w_flags_src = r_flags;
    assign w_flag_hz   = w_is_bcond & w_ex_flags_live;
`endif

    assign w_cond = instr[3:0];

    // Condition evaluation: cond[3:1] picks the test, cond[0] inverts it
    // except for 1111, which is an alias of AL.
    always_comb begin
        w_cond_base = 1'b1;
        case (w_cond[3:1])
            3'b000:  w_cond_base = w_flags_src[2];
            3'b001:  w_cond_base = w_flags_src[1];
            3'b010:  w_cond_base = w_flags_src[3];
            3'b011:  w_cond_base = w_flags_src[0];
            3'b100:  w_cond_base = w_flags_src[1] & ~w_flags_src[2];
            3'b101:  w_cond_base = (w_flags_src[3] == w_flags_src[0]);
            3'b110:  w_cond_base = ~w_flags_src[2] & (w_flags_src[3] == w_flags_src[0]);
            default: w_cond_base = 1'b1;
        endcase
        w_cond_ok = (w_cond[0] && (w_cond != 4'hF)) ? ~w_cond_base : w_cond_base;
    end

    assign w_id_live    = id_valid & ~flush;
    assign hazard_stall = w_id_live & (w_load_use | w_flag_hz);
    assign w_go         = w_id_live & ~hazard_stall;
    assign br_taken     = w_go & (w_is_b | w_is_bl | (w_is_cbz & cbz_zero) |
                                  (w_is_bcond & w_cond_ok));
    assign is_br        = w_go & w_is_br;
    assign reg2loc      = id_valid & w_uses_rt;
    assign reg3loc      = id_valid & w_is_bl;
    assign uncond_br    = id_valid & (w_is_b | w_is_bl);
    assign w_kill       = flush | hazard_stall | ~id_valid | ~w_known;

    // Build the EX control bundle for the instruction currently in ID
    always_comb begin
        w_dec       = '0;
        w_dec.valid = 1'b1;
        if (w_is_addi) begin
            w_dec.reg_write = 1'b1;
            w_dec.alu_src   = 1'b1;
            w_dec.is_addi   = 1'b1;
            w_dec.aluop     = c_ALU_ADD;
            w_dec.rd        = REG_AW'(instr[4:0]);
        end else if (w_is_adds || w_is_subs) begin
            w_dec.reg_write = 1'b1;
            w_dec.flag_en   = 1'b1;
            w_dec.aluop     = w_is_subs ? c_ALU_SUB : c_ALU_ADD;
            w_dec.rd        = REG_AW'(instr[4:0]);
        end else if (w_is_ldur) begin
            w_dec.reg_write  = 1'b1;
            w_dec.alu_src    = 1'b1;
            w_dec.read_en    = 1'b1;
            w_dec.mem_to_reg = c_WB_MEM;
            w_dec.aluop      = c_ALU_ADD;
            w_dec.rd         = REG_AW'(instr[4:0]);
        end else if (w_is_stur) begin
            w_dec.alu_src   = 1'b1;
            w_dec.mem_write = 1'b1;
            w_dec.aluop     = c_ALU_ADD;
        end else if (w_is_bl) begin
            w_dec.reg_write  = 1'b1;
            w_dec.mem_to_reg = c_WB_PC4;
            w_dec.rd         = c_REG_LR;
        end else if (w_is_cbz) begin
            w_dec.aluop = c_ALU_PASSB;
        end else begin
            w_dec.mem_to_reg = c_WB_ALU;
        end
    end

    // ID/EX register: flush always bubbles, otherwise advance unless held
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex <= '0;
        end else if (flush || !stall_in) begin
            r_ex <= w_kill ? '0 : w_dec;
        end
    end

    // Architectural NZCV: commit the EX result whenever EX advances
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags <= 4'b0000;
        end else if (w_ex_flags_live && !stall_in) begin
            r_flags <= alu_nzcv;
        end
    end

    assign ex_valid      = r_ex.valid;
    assign ex_reg_write  = r_ex.reg_write;
    assign ex_alu_src    = r_ex.alu_src;
    assign ex_is_addi    = r_ex.is_addi;
    assign ex_mem_write  = r_ex.mem_write;
    assign ex_read_en    = r_ex.read_en;
    assign ex_flag_en    = r_ex.flag_en;
    assign ex_mem_to_reg = r_ex.mem_to_reg;
    assign ex_aluop      = r_ex.aluop;
    assign ex_rd         = r_ex.rd;
    assign flags_q       = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipelined_control_unit
//  Description : Directed self-checking bench for pipelined_control_unit.
//                Expected EX bundles are queued when an instruction is driven
//                into ID and compared after the following clock edge.
//                Honours CTRL_FLAG_FWD_EN the same way as the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        id_valid, stall_in, flush, cbz_zero;
    logic [3:0]  alu_nzcv;
    logic        reg2loc, reg3loc, uncond_br, br_taken, is_br, hazard_stall;
    logic        ex_valid, ex_reg_write, ex_alu_src, ex_is_addi;
    logic        ex_mem_write, ex_read_en, ex_flag_en;
    logic [1:0]  ex_mem_to_reg;
    logic [2:0]  ex_aluop;
    logic [4:0]  ex_rd;
    logic [3:0]  flags_q;
    logic [16:0] ex_bus;

    int n_cmp = 0;
    int n_err = 0;
    logic [16:0] sb_q[$];

    pipelined_control_unit #(.REG_AW(5), .ALUOP_W(3)) dut (
        .clk(clk), .reset(reset), .instr(instr), .id_valid(id_valid),
        .stall_in(stall_in), .flush(flush), .alu_nzcv(alu_nzcv),
        .cbz_zero(cbz_zero), .reg2loc(reg2loc), .reg3loc(reg3loc),
        .uncond_br(uncond_br), .br_taken(br_taken), .is_br(is_br),
        .hazard_stall(hazard_stall), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_alu_src(ex_alu_src),
        .ex_is_addi(ex_is_addi), .ex_mem_write(ex_mem_write),
        .ex_read_en(ex_read_en), .ex_flag_en(ex_flag_en),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_aluop(ex_aluop), .ex_rd(ex_rd),
        .flags_q(flags_q)
    );

    always #5 clk = ~clk;

    assign ex_bus = {ex_valid, ex_reg_write, ex_alu_src, ex_is_addi, ex_mem_write,
                     ex_read_en, ex_flag_en, ex_mem_to_reg, ex_aluop, ex_rd};

    // Instruction encodings
    localparam logic [31:0] I_LDUR_X3  = {11'b11111000010, 9'd0, 2'b00, 5'd4, 5'd3};
    localparam logic [31:0] I_LDUR_X31 = {11'b11111000010, 9'd0, 2'b00, 5'd4, 5'd31};
    localparam logic [31:0] I_ADDS     = {11'b10101011000, 5'd2, 6'd0, 5'd3, 5'd1};
    localparam logic [31:0] I_ADDS_ZR  = {11'b10101011000, 5'd2, 6'd0, 5'd31, 5'd1};
    localparam logic [31:0] I_SUBS     = {11'b11101011000, 5'd7, 6'd0, 5'd6, 5'd5};
    localparam logic [31:0] I_BLT      = {8'b01010100, 19'd4, 1'b0, 4'b1011};
    localparam logic [31:0] I_CBZ      = {8'b10110100, 19'd8, 5'd9};
    localparam logic [31:0] I_BL       = {6'b100101, 26'd16};
    localparam logic [31:0] I_B        = {6'b000101, 26'd1};
    localparam logic [31:0] I_ADDI     = {10'b1001000100, 12'd5, 5'd1, 5'd2};
    localparam logic [31:0] I_STUR     = {11'b11111000000, 9'd0, 2'b00, 5'd4, 5'd3};
    localparam logic [31:0] I_BR       = {11'b11010110000, 5'd31, 6'd0, 5'd0, 5'd7};

    function automatic logic [16:0] mk(input logic v, rw, asrc, addi, mw, re, fe,
                                       input logic [1:0] m2r, input logic [2:0] op,
                                       input logic [4:0] rd);
        return {v, rw, asrc, addi, mw, re, fe, m2r, op, rd};
    endfunction

    // ARMv8 condition truth table, written per code
    function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive ID inputs at the falling edge, check ID outputs, queue the EX result
    task automatic id_phase(input string tag, input logic [31:0] ins, input logic v, f, s,
                            input logic [3:0] nz, input logic cz,
                            input logic e_br, e_hz, e_isbr, input logic [16:0] e_ex);
        @(negedge clk);
        instr = ins; id_valid = v; flush = f; stall_in = s; alu_nzcv = nz; cbz_zero = cz;
        #1;
        chk({tag, ".br_taken"}, {31'd0, br_taken}, {31'd0, e_br});
        chk({tag, ".hazard"},   {31'd0, hazard_stall}, {31'd0, e_hz});
        chk({tag, ".is_br"},    {31'd0, is_br}, {31'd0, e_isbr});
        sb_q.push_back(e_ex);
    endtask

    task automatic ex_phase(input string tag);
        logic [16:0] e;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk({tag, ".ex"}, {15'd0, ex_bus}, {15'd0, e});
        end
    endtask

    task automatic step(input string tag, input logic [31:0] ins, input logic v, f, s,
                        input logic [3:0] nz, input logic cz,
                        input logic e_br, e_hz, e_isbr, input logic [16:0] e_ex);
        id_phase(tag, ins, v, f, s, nz, cz, e_br, e_hz, e_isbr, e_ex);
        ex_phase(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16:0] B_LDUR3, B_LDUR31, B_ADDS, B_SUBS, B_BR0, B_CBZ, B_BL, B_ADDI, B_STUR;
        B_LDUR3  = mk(1, 1, 1, 0, 0, 1, 0, 2'b01, 3'd2, 5'd3);
        B_LDUR31 = mk(1, 1, 1, 0, 0, 1, 0, 2'b01, 3'd2, 5'd31);
        B_ADDS   = mk(1, 1, 0, 0, 0, 0, 1, 2'b00, 3'd2, 5'd1);
        B_SUBS   = mk(1, 1, 0, 0, 0, 0, 1, 2'b00, 3'd3, 5'd5);
        B_BR0    = mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 3'd0, 5'd0);
        B_CBZ    = mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 3'd0, 5'd0);
        B_BL     = mk(1, 1, 0, 0, 0, 0, 0, 2'b10, 3'd0, 5'd30);
        B_ADDI   = mk(1, 1, 1, 1, 0, 0, 0, 2'b00, 3'd2, 5'd2);
        B_STUR   = mk(1, 0, 1, 0, 1, 0, 0, 2'b00, 3'd2, 5'd0);

        reset = 1'b1; instr = '0; id_valid = 0; stall_in = 0; flush = 0;
        alu_nzcv = 4'hF; cbz_zero = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.ex", {15'd0, ex_bus}, 32'd0);
        chk("reset.flags", {28'd0, flags_q}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Load-use hazard: one bubble, then the dependent ADDS issues
        step("ld",      I_LDUR_X3, 1, 0, 0, 4'h0, 0, 0, 0, 0, B_LDUR3);
        step("lu.hz",   I_ADDS,    1, 0, 0, 4'h0, 0, 0, 1, 0, 17'd0);
        step("lu.go",   I_ADDS,    1, 0, 0, 4'h0, 0, 0, 0, 0, B_ADDS);
        step("subs",    I_SUBS,    1, 0, 0, 4'h0, 0, 0, 0, 0, B_SUBS);
`ifdef CTRL_FLAG_FWD_EN
        step("blt.fwd", I_BLT,     1, 0, 0, 4'b1000, 0, 1, 0, 0, B_BR0);
`else
        step("blt.hz",  I_BLT,     1, 0, 0, 4'b1000, 0, 0, 1, 0, 17'd0);
        step("blt.go",  I_BLT,     1, 0, 0, 4'b0000, 0, 1, 0, 0, B_BR0);
`endif
        chk("blt.flags", {28'd0, flags_q}, 32'h8);

        // CBZ killed by flush, then taken
        step("cbz.fl",  I_CBZ,     1, 1, 0, 4'h0, 1, 0, 0, 0, 17'd0);
        step("cbz",     I_CBZ,     1, 0, 0, 4'h0, 1, 1, 0, 0, B_CBZ);

        // BL held in EX for three stalled cycles
        id_phase("bl",  I_BL,      1, 0, 0, 4'h0, 0, 1, 0, 0, B_BL);
        chk("bl.uncond", {31'd0, uncond_br}, 32'd1);
        chk("bl.reg3loc", {31'd0, reg3loc}, 32'd1);
        ex_phase("bl");
        for (int i = 0; i < 3; i++) begin
            step("bl.hold", I_ADDI, 1, 0, 1, 4'b0110, 0, 0, 0, 0, B_BL);
            chk("bl.hold.flags", {28'd0, flags_q}, 32'h8);
        end
        step("addi",    I_ADDI,    1, 0, 0, 4'h0, 0, 0, 0, 0, B_ADDI);

        // Stalled flag-setter must not commit; flush overrides the stall
        step("adds2",   I_ADDS,    1, 0, 0, 4'h0, 0, 0, 0, 0, B_ADDS);
        step("st.hold", I_LDUR_X3, 1, 0, 1, 4'b0001, 0, 0, 0, 0, B_ADDS);
        step("st.fl",   I_ADDS,    1, 1, 1, 4'b0001, 0, 0, 0, 0, 17'd0);
        chk("st.flags", {28'd0, flags_q}, 32'h8);

        // STUR reads Rt: hazards on a load into its data register
        step("ld2",     I_LDUR_X3, 1, 0, 0, 4'h0, 0, 0, 0, 0, B_LDUR3);
        id_phase("stur.hz", I_STUR, 1, 0, 0, 4'h0, 0, 0, 1, 0, 17'd0);
        chk("stur.reg2loc", {31'd0, reg2loc}, 32'd1);
        ex_phase("stur.hz");
        step("stur",    I_STUR,    1, 0, 0, 4'h0, 0, 0, 0, 0, B_STUR);
        step("br",      I_BR,      1, 0, 0, 4'h0, 0, 0, 0, 1, B_BR0);

        // A load into XZR never creates a hazard
        step("ld31",    I_LDUR_X31, 1, 0, 0, 4'h0, 0, 0, 0, 0, B_LDUR31);
        step("zr.nohz", I_ADDS_ZR,  1, 0, 0, 4'h0, 0, 0, 0, 0, B_ADDS);
        step("cbz.nz",  I_CBZ,      1, 0, 0, 4'h0, 0, 0, 0, 0, B_CBZ);
        step("b",       I_B,        1, 0, 0, 4'h0, 0, 1, 0, 0, B_BR0);
        step("unk",     32'h0,      1, 0, 0, 4'h0, 0, 0, 0, 0, 17'd0);

        // Condition sweep: every code against every committed NZCV value
        for (int f = 0; f < 16; f++) begin
            step("sw.adds", I_ADDS, 1, 0, 0, 4'h0, 0, 0, 0, 0, B_ADDS);
            step("sw.idle", 32'h0,  0, 0, 0, 4'(f), 0, 0, 0, 0, 17'd0);
            chk("sw.flags", {28'd0, flags_q}, 32'(f));
            for (int c = 0; c < 16; c++) begin
                logic [31:0] ins;
                ins = {8'b01010100, 19'd4, 1'b0, 4'(c)};
                step("sw.bcond", ins, 1, 0, 0, 4'(15 - f), 0,
                     cond_ref(4'(c), 4'(f)), 0, 0, B_BR0);
            end
        end

        // Reset while a flag-setting ADDS sits in EX
        step("r.adds",  I_ADDS,    1, 0, 0, 4'h0, 0, 0, 0, 0, B_ADDS);
        @(negedge clk);
        reset = 1'b1; id_valid = 0; alu_nzcv = 4'b0101;
        #1;
        chk("r.async.ex", {15'd0, ex_bus}, 32'd0);
        chk("r.async.flags", {28'd0, flags_q}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step("r.after", 32'h0,     0, 0, 0, 4'hF, 0, 0, 0, 0, 17'd0);
        chk("r.after.flags", {28'd0, flags_q}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
